seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an 8-digit common-cathode 7-segment display. It holds eight BCD digits and eight decimal points, and cycles one active-low common line at a time. A dark blanking gap separates consecutive digits to suppress ghosting. New display data is accepted through a load strobe and applied only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
SCAN_DIV, 1000, clock cycles per digit slot (blank gap plus lit time); must be >= 2
BLANK_CYC, 16, cycles at the start of each slot with all digits dark; must satisfy 0 <= BLANK_CYC < SCAN_DIV

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
bcd_digits  in  32  digit i = bcd_digits[4i+3:4i], i=0..7
dp_in  in  8  dp_in[i] = decimal point of digit i
load  in  1  one-cycle strobe; capture bcd_digits/dp_in into shadow register
load_ack  out  1  one-cycle pulse when shadow data becomes active
frame_tick  out  1  one-cycle pulse each time digit index wraps 7->0
seg_data  out  8  {dp,g,f,e,d,c,b,a}, active-high
seg_com  out  8  digit i enabled when seg_com[i]=0; at most one bit low

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - seg_com=8'hFF, seg_data=8'h00, load_ack=0, frame_tick=0.
  - Slot counter cnt=0, digit index idx=0, active and shadow registers all 0, pending=0.
- Reset mid-operation takes effect immediately: display goes dark and any pending load is dropped.
- Slot counter cnt runs 0..SCAN_DIV-1. When cnt==SCAN_DIV-1: cnt->0 and idx->idx+1 mod 8.
- Two states, decoded from cnt:
  - BLANK (cnt < BLANK_CYC): seg_com=8'hFF, seg_data=8'h00.
  - SHOW (otherwise): seg_com=~(8'b1<<idx); seg_data[6:0]=decode(active digit idx); seg_data[7]=active dp[idx].
- seg_com/seg_data are registered, computed from next-state values, so they align with cnt/idx with no extra cycle of lag.
- Decode table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67. Codes A-F give segments 00; dp is still applied.
- Frame boundary = the edge where cnt==SCAN_DIV-1 and idx==7. frame_tick is high the cycle after that edge.
- Load handshake:
  - A rising edge with load=1 copies the inputs into shadow and sets pending.
  - A repeated load while pending overwrites shadow (latest wins); pending stays set.
  - At a frame boundary with pending=1: active<=shadow, pending<=0, load_ack=1 the next cycle.
  - load on the same edge as a frame boundary: the incoming inputs go straight to active, load_ack pulses, pending clears.
  - load_ack pulses at most once per frame.
- No backpressure: load is always accepted.
- After reset the display shows all zeros ('0' on every digit, dp off) until the first transfer.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - Scanning significance from digit 7 downward, digits equal to 0 that precede the first nonzero digit show seg_data[6:0]=0; dp is still shown.
  - Digit 0 is never blanked.
  - The blank mask is computed from active data and updates only at transfer.
- Undefined: every zero digit shows 3F.

Decomposition:
- Package seg_pkg: NUM_DIGITS=8, COM_OFF=8'hFF, SEG_OFF=8'h00, SEG_0..SEG_9 codes, a state enum {BLANK, SHOW}.
- Sub-module seg_digit_dec: combinational 4-bit -> 7-segment decode using seg_pkg, instantiated once on the muxed active digit.

Test Plan:
Bench uses SCAN_DIV=8, BLANK_CYC=2.
- Reset: hold rst=0 -> seg_com=FF, seg_data=00. Release -> cycles 0-1 show FF/00; cycle 2 shows seg_com=FE, seg_data=3F; idx advances every 8 cycles; frame_tick pulses every 64 cycles.
- Load 32'h8765_4321, dp=00 mid-frame -> old zeros persist to the boundary; load_ack pulses once. Next frame:
  - digit0..3 = 06, 5B, 4F, 66
  - digit4..7 = 6D, 7D, 07, 7F
- Loads 32'h1111_1111 then 32'h2222_2222 in one frame -> only 5B on all digits next frame; exactly one load_ack.
- load coincident with the boundary edge carrying 32'h0000_0009 -> digit0 shows 67 in the slot starting immediately after; load_ack next cycle.
- Digit3=4'hA, dp_in=8'h08 -> digit3 SHOW seg_data=80; other digits unaffected.
- Async reset asserted during digit5 SHOW -> same-cycle seg_com=FF, seg_data=00. After release, digits show 3F, the pending load is discarded, and no load_ack appears.
- With LEADING_ZERO_BLANK_EN: 32'h0000_0042 -> digits 7..2 seg_data=00, digit1=66, digit0=5B. 32'h0 -> digit0=3F, others 00.

Source files
------------

// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants, scan state type and leading-zero helper for the
//            8-digit 7-segment scan controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] COM_OFF    = 8'hFF;
  localparam logic [7:0] SEG_OFF    = 8'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Bit i set when digits i..7 are all zero; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] digits);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (digits[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_digit_dec.sv
// ============================================================================
// Module   : seg_digit_dec
// Purpose  : Combinational BCD to 7-segment {g,f,e,d,c,b,a} decoder; codes
//            A-F produce all segments off.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_digit_dec
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : 8-digit common-cathode scan controller with blanking gap and
//            frame-aligned shadow-register data loading.
// Options  : LEADING_ZERO_BLANK_EN - suppress leading zero digits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd_digits,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com
);

  localparam int unsigned     CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_dig_q, shadow_dig_d, active_dig_q, active_dig_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic          pending_q, pending_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_tick_q, frame_tick_d;
  scan_state_e   state_q, state_d;
  logic [7:0]    show_com_q, show_com_d, show_seg_q, show_seg_d;
  logic          slot_end, frame_end;
  logic [6:0]    dec_seg;
  logic [7:0]    blank_mask;

  // Scan counters and shadow/active handshake.
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    frame_end    = slot_end && (idx_q == 3'd7);
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = slot_end ? idx_q + 3'd1 : idx_q;
    frame_tick_d = frame_end;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    if (load) begin
      shadow_dig_d = bcd_digits;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
    if (frame_end) begin
      // A load on the boundary edge bypasses the shadow stage.
      if (load) begin
        active_dig_d = bcd_digits;
        active_dp_d  = dp_in;
        pending_d    = 1'b0;
        load_ack_d   = 1'b1;
      end else if (pending_q) begin
        active_dig_d = shadow_dig_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
        load_ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  seg_digit_dec u_dec (
    .bcd_i (active_dig_d[{idx_d, 2'b00} +: 4]),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_mask = lz_mask(active_dig_d);
`else
  assign blank_mask = '0;
`endif

  // State register; lit pattern is precomputed from next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BLANK;
      show_com_q <= COM_OFF;
      show_seg_q <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      show_com_q <= show_com_d;
      show_seg_q <= show_seg_d;
    end
  end

  always_comb begin
    state_d    = (32'(cnt_d) < BLANK_CYC) ? BLANK : SHOW;
    show_com_d = ~(8'b1 << idx_d);
    show_seg_d = {active_dp_d[idx_d], blank_mask[idx_d] ? 7'h00 : dec_seg};
  end

  always_comb begin
    seg_com  = COM_OFF;
    seg_data = SEG_OFF;
    if (state_q == SHOW) begin
      seg_com  = show_com_q;
      seg_data = show_seg_q;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// Options  : LEADING_ZERO_BLANK_EN - reference model follows the RTL option.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] bcd_digits;
  logic [7:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [7:0]  seg_data;
  logic [7:0]  seg_com;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // rising edges since reset release

  int          log_e[$];
  logic [31:0] log_d[$];
  logic [7:0]  log_p[$];

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_digits (bcd_digits),
    .dp_in      (dp_in),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .seg_data   (seg_data),
    .seg_com    (seg_com)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] dec_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h67;  default: return 7'h00;
    endcase
  endfunction

  // Expected {seg_com, seg_data, load_ack, frame_tick} after edge kk.
  function automatic logic [17:0] model_out(input int kk);
    int          b, c, i, hi;
    logic [31:0] ad;
    logic [7:0]  ap, com, data;
    logic        ack, tk;
    b  = (kk / 64) * 64;
    ad = '0;
    ap = '0;
    foreach (log_e[j]) if (b > 0 && log_e[j] <= b) begin ad = log_d[j]; ap = log_p[j]; end
    tk  = (kk > 0) && (kk % 64 == 0);
    ack = 1'b0;
    if (tk) foreach (log_e[j]) if (log_e[j] > kk - 64 && log_e[j] <= kk) ack = 1'b1;
    c    = kk % 8;
    i    = (kk / 8) % 8;
    com  = 8'hFF;
    data = 8'h00;
    if (c >= 2) begin
      com[i]    = 1'b0;
      data[6:0] = dec_ref(ad[4*i +: 4]);
      data[7]   = ap[i];
`ifdef LEADING_ZERO_BLANK_EN
      hi = 0;
      for (int j = 0; j < 8; j++) if (ad[4*j +: 4] != 4'd0) hi = j;
      if (i > hi) data[6:0] = 7'h00;
`else
      hi = 0;
`endif
    end
    return {com, data, ack, tk};
  endfunction

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic arm(input logic [31:0] d, input logic [7:0] p);
    load       = 1'b1;
    bcd_digits = d;
    dp_in      = p;
    log_e.push_back(k + 1);
    log_d.push_back(d);
    log_p.push_back(p);
  endtask

  task automatic advance_to(input int phase);
    repeat (64) if (k % 64 != phase) tick();
  endtask

  task automatic test_reset();
    logic [17:0] exp_v;
    rst = 1'b0; load = 1'b0; bcd_digits = '0; dp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seg_com, seg_data, load_ack, frame_tick} !== 18'h3FC00) begin
      errors++;
      $display("FAIL reset_hold got %h/%h/%b/%b exp FF/00/0/0", seg_com, seg_data, load_ack, frame_tick);
    end
    @(negedge clk);
    rst = 1'b1; k = 0;
    log_e.delete(); log_d.delete(); log_p.delete();
    for (int n = 0; n < 130; n++) begin
      if (n > 0) tick();
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL reset_scan k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  task automatic test_single_load();
    logic [17:0] exp_v;
    int acks = 0;
    advance_to(20);
    for (int n = 0; n < 110; n++) begin
      if (n == 0) arm(32'h8765_4321, 8'h00);
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      acks += int'(load_ack);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL single_load k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL single_load_ack_count got %0d exp 1", acks);
    end
  endtask

  task automatic test_latest_wins();
    logic [17:0] exp_v;
    int acks = 0;
    advance_to(5);
    for (int n = 0; n < 130; n++) begin
      if (n == 0)  arm(32'h1111_1111, 8'h00);
      if (n == 10) arm(32'h2222_2222, 8'h00);
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      acks += int'(load_ack);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL latest_wins k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL latest_wins_ack_count got %0d exp 1", acks);
    end
  endtask

  task automatic test_boundary_load();
    logic [17:0] exp_v;
    advance_to(63);
    for (int n = 0; n < 70; n++) begin
      if (n == 0) arm(32'h0000_0009, 8'h00);
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL boundary_load k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  task automatic test_hex_dp();
    logic [17:0] exp_v;
    logic [31:0] d;
    d = $urandom;
    d[15:12] = 4'hA;
    advance_to(30);
    for (int n = 0; n < 110; n++) begin
      if (n == 0) arm(d, 8'h08);
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL hex_dp k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  task automatic test_zero_pattern();
    logic [17:0] exp_v;
    advance_to(10);
    for (int n = 0; n < 190; n++) begin
      if (n == 0)  arm(32'h0000_0042, 8'h00);
      if (n == 64) arm(32'h0000_0000, 8'h00);
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL zero_pattern k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_v;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0 || (k % 64 == 63 && $urandom_range(0, 1) == 1)) begin
        d = {$urandom_range(0, 15), $urandom_range(0, 9)} ^ $urandom;
        arm(d, 8'($urandom));
      end
      tick();
      load = 1'b0;
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL random k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] exp_v;
    advance_to(43);
    arm(32'h5555_5555, 8'hFF);
    tick();
    load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({seg_com, seg_data, load_ack, frame_tick} !== 18'h3FC00) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%b/%b exp FF/00/0/0", seg_com, seg_data, load_ack, frame_tick);
    end
    @(negedge clk);
    rst = 1'b1; k = 0;
    log_e.delete(); log_d.delete(); log_p.delete();
    for (int n = 0; n < 140; n++) begin
      tick();
      exp_v = model_out(k);
      checks++;
      if ({seg_com, seg_data, load_ack, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL after_reset k=%0d got %h exp %h", k, {seg_com, seg_data, load_ack, frame_tick}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_latest_wins();
    test_boundary_load();
    test_hex_dp();
    test_zero_pattern();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
